// File: rtl/noc_pkg.sv
// Shared NoC router types and defaults: flit width, FIFO depth and output directions.
package noc_pkg;

  localparam int NOC_DATA_WIDTH = 32;
  localparam int NOC_FIFO_DEPTH = 4;
  localparam int NUM_DIRS       = 5;

  typedef enum logic [2:0] {
    DIR_N,
    DIR_E,
    DIR_W,
    DIR_S,
    DIR_L
  } dir_e;

endpackage

// File: rtl/fifo_cts_handshake.sv
// Receive side of the RTS/DCTS link handshake: one registered CTS pulse per accepted flit.
module fifo_cts_handshake (
  input  logic clk,
  input  logic rst,
  input  logic drts,
  input  logic full,
  output logic cts,
  output logic write
);

  // ~cts forces a low cycle between grants, so each RTS yields exactly one write.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cts <= 1'b0;
    else     cts <= drts & ~cts & ~full;
  end

  assign write = drts & cts;

endmodule

// File: rtl/router_input_fifo.sv
// Router input port: CTS handshake plus a show-ahead circular FIFO popped by five arbiters.
// Define ROUTER_FIFO_ERR_EN to add a sticky err output for illegal pops/writes.
module router_input_fifo
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int DEPTH      = NOC_FIFO_DEPTH,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  DRTS,
  input  logic [DATA_WIDTH-1:0] RX,
  output logic                  CTS,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  full,
`ifdef ROUTER_FIFO_ERR_EN
  output logic [PTR_W:0]        count,
  output logic                  err
`else
  output logic [PTR_W:0]        count
`endif
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [NUM_DIRS-1:0]   read_en;
  logic                  write;
  logic                  read;

  fifo_cts_handshake u_handshake (
    .clk   (clk),
    .rst   (rst),
    .drts  (DRTS),
    .full  (full),
    .cts   (CTS),
    .write (write)
  );

  always_comb begin
    read_en         = '0;
    read_en[DIR_N]  = read_en_N;
    read_en[DIR_E]  = read_en_E;
    read_en[DIR_W]  = read_en_W;
    read_en[DIR_S]  = read_en_S;
    read_en[DIR_L]  = read_en_L;
  end

  // Any combination of enables is a single pop; pops on empty are dropped.
  assign read = (|read_en) & ~empty;

  // NOTE: storage has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (write) mem[wr_ptr] <= RX;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (write) wr_ptr <= wr_ptr + PTR_W'(1);
      if (read)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({write, read})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign Data_out = mem[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);

`ifdef ROUTER_FIFO_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (((|read_en) && empty) ||
                 ($countones(read_en) > 1) ||
                 (write && full)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_router_input_fifo.sv
// Directed bench for router_input_fifo: handshake timing, fill/backpressure, wrap and async reset.
module tb_router_input_fifo;
  import noc_pkg::*;

  localparam int DW    = 32;
  localparam int PTR_W = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           DRTS = 1'b0;
  logic [DW-1:0]  RX = '0;
  logic           read_en_N = 1'b0;
  logic           read_en_E = 1'b0;
  logic           read_en_W = 1'b0;
  logic           read_en_S = 1'b0;
  logic           read_en_L = 1'b0;
  logic           CTS;
  logic [DW-1:0]  Data_out;
  logic           empty;
  logic           full;
  logic [PTR_W:0] count;
`ifdef ROUTER_FIFO_ERR_EN
  logic           err;
`endif

  int total = 0;
  int bad   = 0;

  router_input_fifo #(.DATA_WIDTH(DW), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .DRTS      (DRTS),
    .RX        (RX),
    .CTS       (CTS),
    .read_en_N (read_en_N),
    .read_en_E (read_en_E),
    .read_en_W (read_en_W),
    .read_en_S (read_en_S),
    .read_en_L (read_en_L),
    .Data_out  (Data_out),
    .empty     (empty),
    .full      (full),
`ifdef ROUTER_FIFO_ERR_EN
    .count     (count),
    .err       (err)
`else
    .count     (count)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_flit(input logic [DW-1:0] d, input string name);
    bit seen = 1'b0;
    DRTS = 1'b1;
    RX   = d;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick;
      seen = CTS;
    end
    total++;
    if (seen !== 1'b1) begin
      bad++;
      $display("FAIL %s_cts got cts=0 exp cts=1 within 20 cycles", name);
      DRTS = 1'b0;
    end else begin
      tick;
      DRTS = 1'b0;
    end
  endtask

  task automatic pop(input dir_e d);
    case (d)
      DIR_N:   read_en_N = 1'b1;
      DIR_E:   read_en_E = 1'b1;
      DIR_W:   read_en_W = 1'b1;
      DIR_S:   read_en_S = 1'b1;
      default: read_en_L = 1'b1;
    endcase
    tick;
    {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L} = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({CTS, empty, full, count} !== {1'b0, 1'b1, 1'b0, 3'd0}) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got cts=%b empty=%b full=%b count=%0d exp cts=0 empty=1 full=0 count=0",
                 i, CTS, empty, full, count);
      end
      tick;
    end
`ifdef ROUTER_FIFO_ERR_EN
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL reset_err got=%b exp=0", err);
    end
`endif
  endtask

  task automatic test_single;
    DRTS = 1'b1;
    RX   = 32'hA5A5_0001;
    total++;
    if (CTS !== 1'b0) begin
      bad++;
      $display("FAIL single_cts_early got=%b exp=0", CTS);
    end
    tick;
    total++;
    if (CTS !== 1'b1) begin
      bad++;
      $display("FAIL single_cts_rise got=%b exp=1", CTS);
    end
    tick;
    DRTS = 1'b0;
    total++;
    if ({CTS, empty, count, Data_out} !== {1'b0, 1'b0, 3'd1, 32'hA5A5_0001}) begin
      bad++;
      $display("FAIL single_write got cts=%b empty=%b count=%0d data=%h exp cts=0 empty=0 count=1 data=a5a50001",
               CTS, empty, count, Data_out);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if (CTS !== 1'b0) begin
        bad++;
        $display("FAIL single_no_second_cts cyc=%0d got=%b exp=0", i, CTS);
      end
    end
  endtask

  task automatic test_fill;
    logic [DW-1:0] exp_order [4] = '{32'h2, 32'h3, 32'h4, 32'h5};
    total++;
    if (Data_out !== 32'hA5A5_0001) begin
      bad++;
      $display("FAIL fill_drain_head got=%h exp=a5a50001", Data_out);
    end
    pop(DIR_N);
    for (int i = 1; i <= 4; i++) send_flit(DW'(i), "fill");
    total++;
    if ({full, count} !== {1'b1, 3'd4}) begin
      bad++;
      $display("FAIL fill_full got full=%b count=%0d exp full=1 count=4", full, count);
    end
    DRTS = 1'b1;
    RX   = 32'h5;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if ({CTS, full} !== {1'b0, 1'b1}) begin
        bad++;
        $display("FAIL fill_blocked cyc=%0d got cts=%b full=%b exp cts=0 full=1", i, CTS, full);
      end
    end
    total++;
    if (Data_out !== 32'h1) begin
      bad++;
      $display("FAIL fill_head got=%h exp=00000001", Data_out);
    end
    pop(DIR_E);
    total++;
    if ({CTS, full, count} !== {1'b0, 1'b0, 3'd3}) begin
      bad++;
      $display("FAIL fill_after_pop got cts=%b full=%b count=%0d exp cts=0 full=0 count=3", CTS, full, count);
    end
    tick;
    total++;
    if (CTS !== 1'b1) begin
      bad++;
      $display("FAIL fill_cts_after_pop got=%b exp=1", CTS);
    end
    tick;
    DRTS = 1'b0;
    total++;
    if ({full, count} !== {1'b1, 3'd4}) begin
      bad++;
      $display("FAIL fill_refull got full=%b count=%0d exp full=1 count=4", full, count);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (Data_out !== exp_order[i]) begin
        bad++;
        $display("FAIL fill_order idx=%0d got=%h exp=%h", i, Data_out, exp_order[i]);
      end
      pop(DIR_W);
    end
    total++;
    if ({empty, count} !== {1'b1, 3'd0}) begin
      bad++;
      $display("FAIL fill_drained got empty=%b count=%0d exp empty=1 count=0", empty, count);
    end
  endtask

  task automatic test_back_to_back_rw;
    send_flit(32'h20, "simul_pre0");
    send_flit(32'h21, "simul_pre1");
    DRTS = 1'b1;
    RX   = 32'h10;
    tick;
    total++;
    if (CTS !== 1'b1) begin
      bad++;
      $display("FAIL simul_cts got=%b exp=1", CTS);
    end
    read_en_L = 1'b1;
    tick;
    read_en_L = 1'b0;
    DRTS      = 1'b0;
    total++;
    if ({count, Data_out} !== {3'd2, 32'h21}) begin
      bad++;
      $display("FAIL simul_rw got count=%0d head=%h exp count=2 head=00000021", count, Data_out);
    end
    read_en_N = 1'b1;
    read_en_S = 1'b1;
    tick;
    read_en_N = 1'b0;
    read_en_S = 1'b0;
    total++;
    if ({count, Data_out} !== {3'd1, 32'h10}) begin
      bad++;
      $display("FAIL multi_en_single_pop got count=%0d head=%h exp count=1 head=00000010", count, Data_out);
    end
    pop(DIR_L);
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL simul_drained got empty=%b exp=1", empty);
    end
  endtask

  task automatic test_underflow_wrap;
    pop(DIR_N);
    total++;
    if ({empty, full, count} !== {1'b1, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL underflow got empty=%b full=%b count=%0d exp empty=1 full=0 count=0", empty, full, count);
    end
`ifdef ROUTER_FIFO_ERR_EN
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL underflow_err got=%b exp=1", err);
    end
`endif
    for (int i = 0; i < 10; i++) begin
      logic [DW-1:0] d;
      d = 32'h100 + DW'(i);
      send_flit(d, "wrap");
      total++;
      if ({count, Data_out} !== {3'd1, d}) begin
        bad++;
        $display("FAIL wrap idx=%0d got count=%0d head=%h exp count=1 head=%h", i, count, Data_out, d);
      end
      pop(DIR_S);
    end
    total++;
    if ({empty, count} !== {1'b1, 3'd0}) begin
      bad++;
      $display("FAIL wrap_final got empty=%b count=%0d exp empty=1 count=0", empty, count);
    end
  endtask

  task automatic test_async_reset;
    send_flit(32'h30, "areset_pre0");
    send_flit(32'h31, "areset_pre1");
    send_flit(32'h32, "areset_pre2");
    DRTS = 1'b1;
    RX   = 32'h33;
    tick;
    total++;
    if ({CTS, count} !== {1'b1, 3'd3}) begin
      bad++;
      $display("FAIL areset_setup got cts=%b count=%0d exp cts=1 count=3", CTS, count);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({CTS, empty, full, count} !== {1'b0, 1'b1, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL areset_immediate got cts=%b empty=%b full=%b count=%0d exp cts=0 empty=1 full=0 count=0",
               CTS, empty, full, count);
    end
    tick;
    rst = 1'b0;
`ifdef ROUTER_FIFO_ERR_EN
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL areset_err got=%b exp=0", err);
    end
`endif
    total++;
    if (CTS !== 1'b0) begin
      bad++;
      $display("FAIL areset_release_cts got=%b exp=0", CTS);
    end
    tick;
    total++;
    if (CTS !== 1'b1) begin
      bad++;
      $display("FAIL areset_cts_regrant got=%b exp=1", CTS);
    end
    tick;
    DRTS = 1'b0;
    total++;
    if ({count, Data_out} !== {3'd1, 32'h33}) begin
      bad++;
      $display("FAIL areset_write got count=%0d head=%h exp count=1 head=00000033", count, Data_out);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fill;
    test_back_to_back_rw;
    test_underflow_wrap;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
